// File: rtl/bcd_count_n.sv
// ============================================================================
// Module   : bcd_count_n
// Brief    : N-digit BCD up/down counter with hold, checked parallel load and
//            programmable wrap value; wrap/err are one-cycle pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_count_n #(
  parameter int DIGITS  = 2,
  parameter int MAX_VAL = 99
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dis,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] dec,
  output logic                wrap,
  output logic                err
);

  localparam int C_W = 4 * DIGITS;

  function automatic logic [C_W-1:0] to_bcd(input int unsigned v);
    logic [C_W-1:0] r;
    int unsigned    t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t           = t / 10;
    end
    return r;
  endfunction

  localparam logic [C_W-1:0] C_MAX_BCD = to_bcd(MAX_VAL);

  logic [C_W-1:0] dec_q, dec_d;
  logic           wrap_q, wrap_d;
  logic           err_q, err_d;

  logic [C_W-1:0] w_inc;
  logic [C_W-1:0] w_decr;
  logic           w_at_max;
  logic           w_at_zero;
  logic           w_digits_ok;
  logic           w_load_ok;

  assign w_at_max  = (dec_q == C_MAX_BCD);
  assign w_at_zero = (dec_q == '0);

  // Digit-wise ripple carry/borrow; the counter never holds a binary value.
  always_comb begin
    logic carry;
    logic borrow;
    w_inc  = dec_q;
    w_decr = dec_q;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (dec_q[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = dec_q[4*i +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
      if (borrow) begin
        if (dec_q[4*i +: 4] == 4'd0) begin
          w_decr[4*i +: 4] = 4'd9;
        end else begin
          w_decr[4*i +: 4] = dec_q[4*i +: 4] - 4'd1;
          borrow           = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        w_digits_ok = 1'b0;
      end
    end
  end

  // With every nibble in 0-9, packed BCD orders the same as its decimal value.
  assign w_load_ok = w_digits_ok && (load_val <= C_MAX_BCD);

  always_comb begin
    dec_d  = dec_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      if (w_load_ok) begin
        dec_d = load_val;
      end else begin
        err_d = 1'b1;
      end
    end else if (!dis) begin
      if (up) begin
        if (w_at_max) begin
          dec_d  = '0;
          wrap_d = 1'b1;
        end else begin
          dec_d = w_inc;
        end
      end else begin
        if (w_at_zero) begin
          dec_d  = C_MAX_BCD;
          wrap_d = 1'b1;
        end else begin
          dec_d = w_decr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dec_q  <= dec_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign dec  = dec_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_count_n.sv
// ============================================================================
// Module   : tb_bcd_count_n
// Brief    : Directed self-checking bench for bcd_count_n in three configs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_count_n;

  logic clk;
  logic reset;

  logic       a_dis, a_up, a_load;
  logic [7:0] a_lv, a_dec;
  logic       a_wrap, a_err;

  logic        b_dis, b_up, b_load;
  logic [11:0] b_lv, b_dec;
  logic        b_wrap, b_err;

  logic       c_dis, c_up, c_load;
  logic [7:0] c_lv, c_dec;
  logic       c_wrap, c_err;

  int total;
  int bad;

  bcd_count_n #(.DIGITS(2), .MAX_VAL(59)) u_a (
    .clk(clk), .reset(reset), .dis(a_dis), .up(a_up), .load(a_load),
    .load_val(a_lv), .dec(a_dec), .wrap(a_wrap), .err(a_err)
  );

  bcd_count_n #(.DIGITS(3), .MAX_VAL(999)) u_b (
    .clk(clk), .reset(reset), .dis(b_dis), .up(b_up), .load(b_load),
    .load_val(b_lv), .dec(b_dec), .wrap(b_wrap), .err(b_err)
  );

  bcd_count_n #(.DIGITS(2), .MAX_VAL(99)) u_c (
    .clk(clk), .reset(reset), .dis(c_dis), .up(c_up), .load(c_load),
    .load_val(c_lv), .dec(c_dec), .wrap(c_wrap), .err(c_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_dis = 1'b1; a_up = 1'b1; a_load = 1'b0; a_lv = 8'h00;
    b_dis = 1'b1; b_up = 1'b1; b_load = 1'b0; b_lv = 12'h000;
    c_dis = 1'b1; c_up = 1'b1; c_load = 1'b0; c_lv = 8'h00;
    tick();
    total++;
    if (a_dec !== 8'h00 || a_wrap !== 1'b0 || a_err !== 1'b0) begin
      bad++; $display("FAIL reset_init: dec=%h wrap=%b err=%b want 00/0/0", a_dec, a_wrap, a_err);
    end
    reset = 1'b1;
    a_load = 1'b1; a_lv = 8'h37;
    tick();
    a_load = 1'b0;
    total++;
    if (a_dec !== 8'h37) begin
      bad++; $display("FAIL reset_preload: dec=%h want 37", a_dec);
    end
    a_dis = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (a_dec !== 8'h00 || a_wrap !== 1'b0 || a_err !== 1'b0) begin
      bad++; $display("FAIL reset_async: dec=%h wrap=%b err=%b want 00/0/0", a_dec, a_wrap, a_err);
    end
    tick();
    total++;
    if (a_dec !== 8'h00) begin
      bad++; $display("FAIL reset_held: dec=%h want 00", a_dec);
    end
    a_dis = 1'b1;
    #2;
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (a_dec !== 8'h00 || a_wrap !== 1'b0 || a_err !== 1'b0) begin
        bad++; $display("FAIL reset_hold%0d: dec=%h wrap=%b err=%b want 00/0/0", k, a_dec, a_wrap, a_err);
      end
    end
  endtask

  task automatic test_up_wrap();
    int         e;
    logic [7:0] exp;
    a_up = 1'b1; a_dis = 1'b0;
    for (int k = 1; k <= 61; k++) begin
      tick();
      e   = k % 60;
      exp = {4'(e / 10), 4'(e % 10)};
      total++;
      if (a_dec !== exp || a_wrap !== (k == 60)) begin
        bad++; $display("FAIL up_edge%0d: dec=%h wrap=%b want %h/%b", k, a_dec, a_wrap, exp, (k == 60));
      end
    end
    a_dis = 1'b1;
    total++;
    if (a_dec !== 8'h01) begin
      bad++; $display("FAIL up_final: dec=%h want 01", a_dec);
    end
  endtask

  task automatic test_down_wrap();
    int         e;
    logic [7:0] exp;
    a_load = 1'b1; a_lv = 8'h10; a_dis = 1'b1;
    tick();
    a_load = 1'b0; a_up = 1'b0; a_dis = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e   = (k <= 10) ? 10 - k : 70 - k;
      exp = {4'(e / 10), 4'(e % 10)};
      total++;
      if (a_dec !== exp || a_wrap !== (k == 11)) begin
        bad++; $display("FAIL down_edge%0d: dec=%h wrap=%b want %h/%b", k, a_dec, a_wrap, exp, (k == 11));
      end
    end
    a_dis = 1'b1;
  endtask

  task automatic test_back_to_back();
    a_load = 1'b1; a_lv = 8'h59;
    tick();
    a_load = 1'b0; a_dis = 1'b0; a_up = 1'b1;
    tick();
    total++;
    if (a_dec !== 8'h00 || a_wrap !== 1'b1) begin
      bad++; $display("FAIL b2b_first: dec=%h wrap=%b want 00/1", a_dec, a_wrap);
    end
    a_up = 1'b0;
    tick();
    total++;
    if (a_dec !== 8'h59 || a_wrap !== 1'b1) begin
      bad++; $display("FAIL b2b_second: dec=%h wrap=%b want 59/1", a_dec, a_wrap);
    end
    a_dis = 1'b1;
    tick();
    total++;
    if (a_dec !== 8'h59 || a_wrap !== 1'b0) begin
      bad++; $display("FAIL b2b_hold: dec=%h wrap=%b want 59/0", a_dec, a_wrap);
    end
  endtask

  task automatic test_load();
    logic [7:0] lv  [6] = '{8'h42, 8'h4A, 8'h75, 8'h59, 8'h60, 8'h0F};
    logic [7:0] exd [6] = '{8'h42, 8'h42, 8'h42, 8'h59, 8'h59, 8'h59};
    logic       exe [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
    a_dis = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a_load = 1'b1; a_lv = lv[k];
      tick();
      total++;
      if (a_dec !== exd[k] || a_err !== exe[k] || a_wrap !== 1'b0) begin
        bad++; $display("FAIL load_%h: dec=%h err=%b wrap=%b want %h/%b/0", lv[k], a_dec, a_err, a_wrap, exd[k], exe[k]);
      end
    end
    a_load = 1'b0;
    tick();
    total++;
    if (a_dec !== 8'h59 || a_err !== 1'b0) begin
      bad++; $display("FAIL load_errclr: dec=%h err=%b want 59/0", a_dec, a_err);
    end
  endtask

  task automatic test_direction();
    b_load = 1'b1; b_lv = 12'h100; b_dis = 1'b1;
    tick();
    b_load = 1'b0; b_dis = 1'b0; b_up = 1'b0;
    tick();
    total++;
    if (b_dec !== 12'h099 || b_wrap !== 1'b0) begin
      bad++; $display("FAIL dir_down: dec=%h wrap=%b want 099/0", b_dec, b_wrap);
    end
    b_up = 1'b1;
    tick();
    total++;
    if (b_dec !== 12'h100 || b_wrap !== 1'b0) begin
      bad++; $display("FAIL dir_up: dec=%h wrap=%b want 100/0", b_dec, b_wrap);
    end
    b_load = 1'b1; b_lv = 12'h999;
    tick();
    b_load = 1'b0;
    tick();
    total++;
    if (b_dec !== 12'h000 || b_wrap !== 1'b1) begin
      bad++; $display("FAIL dir_wrap_up: dec=%h wrap=%b want 000/1", b_dec, b_wrap);
    end
    b_up = 1'b0;
    tick();
    total++;
    if (b_dec !== 12'h999 || b_wrap !== 1'b1) begin
      bad++; $display("FAIL dir_wrap_down: dec=%h wrap=%b want 999/1", b_dec, b_wrap);
    end
    tick();
    total++;
    if (b_dec !== 12'h998 || b_wrap !== 1'b0) begin
      bad++; $display("FAIL dir_after_wrap: dec=%h wrap=%b want 998/0", b_dec, b_wrap);
    end
    b_dis = 1'b1;
  endtask

  task automatic test_load_vs_wrap();
    c_load = 1'b1; c_lv = 8'h99; c_dis = 1'b1;
    tick();
    total++;
    if (c_dec !== 8'h99) begin
      bad++; $display("FAIL lvw_preload: dec=%h want 99", c_dec);
    end
    c_dis = 1'b0; c_up = 1'b1; c_lv = 8'h05;
    tick();
    total++;
    if (c_dec !== 8'h05 || c_wrap !== 1'b0 || c_err !== 1'b0) begin
      bad++; $display("FAIL lvw_load: dec=%h wrap=%b err=%b want 05/0/0", c_dec, c_wrap, c_err);
    end
    c_load = 1'b0;
    tick();
    total++;
    if (c_dec !== 8'h06) begin
      bad++; $display("FAIL lvw_count: dec=%h want 06", c_dec);
    end
    c_dis = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_back_to_back();
    test_load();
    test_direction();
    test_load_vs_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
